rram_sweep_sequencer: RTL and testbench
=======================================

Name: rram_sweep_sequencer

Overview:
- Sequences the word-level RRAM operation FSM across an address sweep and across programming ranges.
- Latches the sweep configuration from the SPI register array when a go arrives.
- Walks addresses from start to stop in step increments; at each address, walks range index 0..num_levels.
- Issues one req/ack handshake per (address, range) pair, counts failures and reports done/abort.
- Sits between the SPI register array outputs and the per-operation FSM, and drives rangei back to the register array's range mux.

Parameters:
- ADDR_BITS, 16, width of the address start/stop/step fields and addr_out.
- RANGE_LOG2, 2, width of num_levels and rangei.
- FAIL_CNT_BITS, 16, width of the saturating failure counter.

Ports:
- mclk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- go  input  1  level start request (fsm_go from register array).
- use_multi_addrs  input  1  1 = sweep start..stop; 0 = address_start only.
- loop_mode  input  1  1 = restart the sweep after completion while go stays high.
- ignore_failures  input  1  0 = abort on the first failed op.
- address_start  input  ADDR_BITS  first address.
- address_stop  input  ADDR_BITS  last address, inclusive.
- address_step  input  ADDR_BITS  address increment.
- num_levels  input  RANGE_LOG2  last range index, inclusive.
- op_req  output  1  operation request to the op FSM.
- op_ack  input  1  op FSM completion, 1-cycle pulse.
- op_fail  input  1  op result, valid only with op_ack.
- addr_out  output  ADDR_BITS  current address; stable while op_req is high.
- rangei  output  RANGE_LOG2  current range index; stable while op_req is high.
- busy  output  1  high in every state except IDLE.
- done  output  1  1-cycle pulse on sweep end.
- aborted  output  1  sticky; set by a failure abort, cleared at the next start.
- fail_count  output  FAIL_CNT_BITS  saturating count of op_fail acks.
- state  output  3  current state, for the diagnostic readback register.

Behaviour:
- Reset (rst=1 at a mclk edge) gives state=IDLE, op_req=0, done=0, busy=0, aborted=0, fail_count=0, addr_out=0, rangei=0.
  - Reset wins over every other event, including mid-handshake; an op_ack arriving in the reset cycle is ignored.
- States: IDLE=0, ISSUE=1, WAIT=2, NEXT=3, FIN=4. Encodings 5-7 are unreachable and recover to IDLE.
- IDLE, when go=1:
  - Latch all configuration inputs (start, stop, step, num_levels, mode bits) into shadow registers.
  - Clear fail_count and aborted; set addr_out=address_start, rangei=0.
  - If use_multi_addrs=1 and start>stop, go to FIN (zero ops). Otherwise go to ISSUE.
- ISSUE: assert op_req (registered). op_req is high the cycle after entry; go to WAIT.
- WAIT: hold op_req=1 until op_ack=1.
  - On ack, op_req drops in the next cycle.
  - If op_fail=1, increment fail_count, saturating at all-ones.
  - If op_fail=1 and ignore_failures=0: set aborted, go to FIN.
  - Otherwise go to NEXT.
- NEXT, range loop is the inner loop:
  - If rangei<num_levels: rangei+1, go to ISSUE.
  - Else rangei=0, then the address advance below.
- Address advance:
  - Compute sum = addr_out + step at ADDR_BITS+1 bits.
  - Sweep ends if any of: use_multi_addrs=0, step=0, sum carry out, or sum>stop. Ending goes to FIN.
  - Otherwise addr_out = sum[ADDR_BITS-1:0], go to ISSUE.
- FIN: pulse done for one cycle.
  - If loop_mode=1, go still high and aborted=0: reload addr_out=start, rangei=0, go to ISSUE. fail_count accumulates across loops.
  - Otherwise go to IDLE.
- go dropping mid-sweep does not cancel the op in flight. It only prevents the loop_mode restart.
- Configuration inputs changing while busy have no effect; only the shadow copies are used.
- Minimum single-op latency: go sampled → op_req at +2 cycles; ack → done at +2 cycles.
- op_ack outside WAIT is ignored.

Decomposition:
- Shared package holds: the state encodings (SEQ_IDLE..SEQ_FIN), SEQ_STATE_BITS=3, and the default widths tied to `ADDR_BITS_N and `PROG_CNFG_RANGES_LOG2_N.
- One sub-module, rram_addr_stepper: the ADDR_BITS+1 adder plus end-of-sweep compare (sum, carry, step==0, sum>stop). It is combinational and reusable by the read path.

Test Plan:
- Single address: use_multi_addrs=0, start=0x10, num_levels=0, ack with fail=0 → exactly one op_req at addr 0x10, rangei 0; done pulse; fail_count=0.
- Sweep: start=2, stop=8, step=3, num_levels=1 → op order (2,0) (2,1) (5,0) (5,1) (8,0) (8,1), then done; 6 handshakes.
- Wrap and empty sweeps:
  - start=0xFFF0, stop=0xFFFF, step=0x20 → single address 0xFFF0, no wrap.
  - start=9, stop=3 → done with zero op_req.
- Abort: ignore_failures=0, fail on the 2nd ack → aborted=1, fail_count=1, done, no 3rd op_req. Same run with ignore_failures=1 → all ops issued, fail_count=1, aborted=0.
- loop_mode=1 over a 2-op sweep: hold go high for 3 done pulses, drop go during the 4th pass → the in-flight op completes, next done, IDLE; fail_count accumulated across passes.
- Reset mid-WAIT with op_req=1 → next cycle op_req=0, state=IDLE; an op_ack arriving after reset causes no state change.

Source files
------------

// File: rtl/rram_sweep_sequencer_pkg.sv
// Shared types and default widths for the RRAM address/range sweep sequencer.
`ifndef ADDR_BITS_N
`define ADDR_BITS_N 16
`endif
`ifndef PROG_CNFG_RANGES_LOG2_N
`define PROG_CNFG_RANGES_LOG2_N 2
`endif

package rram_sweep_sequencer_pkg;

  localparam int SEQ_STATE_BITS    = 3;
  localparam int ADDR_BITS_DEF     = `ADDR_BITS_N;
  localparam int RANGE_LOG2_DEF    = `PROG_CNFG_RANGES_LOG2_N;
  localparam int FAIL_CNT_BITS_DEF = 16;

  typedef enum logic [SEQ_STATE_BITS-1:0] {
    SEQ_IDLE  = 3'd0,
    SEQ_ISSUE = 3'd1,
    SEQ_WAIT  = 3'd2,
    SEQ_NEXT  = 3'd3,
    SEQ_FIN   = 3'd4
  } seq_state_t;

endpackage

// File: rtl/rram_addr_stepper.sv
// Combinational address advance: widened add plus end-of-sweep detection.
module rram_addr_stepper
  import rram_sweep_sequencer_pkg::*;
#(
  parameter int ADDR_BITS = ADDR_BITS_DEF
) (
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [ADDR_BITS-1:0] step,
  input  logic [ADDR_BITS-1:0] stop,
  output logic [ADDR_BITS-1:0] next_addr,
  output logic                 sweep_end
);

  logic [ADDR_BITS:0] sum;

  // One extra bit so a step past the top of the address space ends the sweep instead of wrapping.
  assign sum       = {1'b0, addr} + {1'b0, step};
  assign next_addr = sum[ADDR_BITS-1:0];
  assign sweep_end = sum[ADDR_BITS] || (step == '0) || (sum > {1'b0, stop});

endmodule

// File: rtl/rram_sweep_sequencer.sv
// Walks an address sweep and, per address, every range index, issuing one op handshake per pair.
module rram_sweep_sequencer
  import rram_sweep_sequencer_pkg::*;
#(
  parameter int ADDR_BITS     = ADDR_BITS_DEF,
  parameter int RANGE_LOG2    = RANGE_LOG2_DEF,
  parameter int FAIL_CNT_BITS = FAIL_CNT_BITS_DEF
) (
  input  logic                      mclk,
  input  logic                      rst,
  input  logic                      go,
  input  logic                      use_multi_addrs,
  input  logic                      loop_mode,
  input  logic                      ignore_failures,
  input  logic [ADDR_BITS-1:0]      address_start,
  input  logic [ADDR_BITS-1:0]      address_stop,
  input  logic [ADDR_BITS-1:0]      address_step,
  input  logic [RANGE_LOG2-1:0]     num_levels,
  output logic                      op_req,
  input  logic                      op_ack,
  input  logic                      op_fail,
  output logic [ADDR_BITS-1:0]      addr_out,
  output logic [RANGE_LOG2-1:0]     rangei,
  output logic                      busy,
  output logic                      done,
  output logic                      aborted,
  output logic [FAIL_CNT_BITS-1:0]  fail_count,
  output logic [SEQ_STATE_BITS-1:0] state
);

  seq_state_t state_q, state_d;

  logic [ADDR_BITS-1:0]  start_sh, stop_sh, step_sh;
  logic [RANGE_LOG2-1:0] levels_sh;
  logic                  multi_sh, loop_sh, ignore_sh;

  logic [ADDR_BITS-1:0] next_addr;
  logic                 step_end, sweep_end, more_ranges, restart;

  rram_addr_stepper #(.ADDR_BITS(ADDR_BITS)) u_stepper (
    .addr      (addr_out),
    .step      (step_sh),
    .stop      (stop_sh),
    .next_addr (next_addr),
    .sweep_end (step_end)
  );

  assign sweep_end   = !multi_sh || step_end;
  assign more_ranges = rangei < levels_sh;
  assign restart     = loop_sh && go && !aborted;

  always_ff @(posedge mclk) begin
    if (rst) state_q <= SEQ_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      SEQ_IDLE:  if (go) state_d = (use_multi_addrs && (address_start > address_stop)) ? SEQ_FIN : SEQ_ISSUE;
      SEQ_ISSUE: state_d = SEQ_WAIT;
      SEQ_WAIT:  if (op_ack) state_d = (op_fail && !ignore_sh) ? SEQ_FIN : SEQ_NEXT;
      SEQ_NEXT:  state_d = (more_ranges || !sweep_end) ? SEQ_ISSUE : SEQ_FIN;
      SEQ_FIN:   state_d = restart ? SEQ_ISSUE : SEQ_IDLE;
      default:   state_d = SEQ_IDLE;
    endcase
  end

  always_comb begin
    busy  = (state_q != SEQ_IDLE);
    done  = (state_q == SEQ_FIN);
    state = state_q;
  end

  // op_req mirrors residence in WAIT but is registered so the op FSM sees a clean level.
  always_ff @(posedge mclk) begin
    if (rst) op_req <= 1'b0;
    else     op_req <= (state_d == SEQ_WAIT);
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      addr_out   <= '0;
      rangei     <= '0;
      fail_count <= '0;
      aborted    <= 1'b0;
      start_sh   <= '0;
      stop_sh    <= '0;
      step_sh    <= '0;
      levels_sh  <= '0;
      multi_sh   <= 1'b0;
      loop_sh    <= 1'b0;
      ignore_sh  <= 1'b0;
    end else begin
      case (state_q)
        SEQ_IDLE: if (go) begin
          start_sh   <= address_start;
          stop_sh    <= address_stop;
          step_sh    <= address_step;
          levels_sh  <= num_levels;
          multi_sh   <= use_multi_addrs;
          loop_sh    <= loop_mode;
          ignore_sh  <= ignore_failures;
          fail_count <= '0;
          aborted    <= 1'b0;
          addr_out   <= address_start;
          rangei     <= '0;
        end
        SEQ_WAIT: if (op_ack && op_fail) begin
          if (fail_count != '1) fail_count <= fail_count + 1'b1;
          if (!ignore_sh)       aborted    <= 1'b1;
        end
        SEQ_NEXT: begin
          if (more_ranges) begin
            rangei <= rangei + 1'b1;
          end else begin
            rangei <= '0;
            if (!sweep_end) addr_out <= next_addr;
          end
        end
        SEQ_FIN: if (restart) begin
          addr_out <= start_sh;
          rangei   <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rram_sweep_sequencer.sv
// Self-checking bench: directed and random sweeps compared with an op-list reference model.
module tb_rram_sweep_sequencer;

  logic        mclk = 1'b0;
  logic        rst = 1'b1;
  logic        go = 1'b0;
  logic        use_multi_addrs = 1'b0;
  logic        loop_mode = 1'b0;
  logic        ignore_failures = 1'b0;
  logic [15:0] address_start = '0;
  logic [15:0] address_stop = '0;
  logic [15:0] address_step = '0;
  logic [1:0]  num_levels = '0;
  logic        op_ack = 1'b0;
  logic        op_fail = 1'b0;
  logic        op_req;
  logic [15:0] addr_out;
  logic [1:0]  rangei;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [15:0] fail_count;
  logic [2:0]  state;

  int tests = 0;
  int fails = 0;
  int got_q[$];
  int exp_q[$];

  rram_sweep_sequencer dut (
    .mclk            (mclk),
    .rst             (rst),
    .go              (go),
    .use_multi_addrs (use_multi_addrs),
    .loop_mode       (loop_mode),
    .ignore_failures (ignore_failures),
    .address_start   (address_start),
    .address_stop    (address_stop),
    .address_step    (address_step),
    .num_levels      (num_levels),
    .op_req          (op_req),
    .op_ack          (op_ack),
    .op_fail         (op_fail),
    .addr_out        (addr_out),
    .rangei          (rangei),
    .busy            (busy),
    .done            (done),
    .aborted         (aborted),
    .fail_count      (fail_count),
    .state           (state)
  );

  always #5 mclk = ~mclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int pack_op(input logic [15:0] a, input logic [1:0] r);
    return (int'(a) << 2) | int'(r);
  endfunction

  // Reference: enumerate (address, range) pairs from the sweep rules, then apply failures and passes.
  task automatic model(input logic [15:0] st, input logic [15:0] sp, input logic [15:0] stp,
                       input logic [1:0] nl, input bit multi, input bit ign, input bit loopm,
                       input logic [31:0] fmask, input int passes,
                       output int exp_fc, output bit exp_ab, output int exp_done);
    int base[$];
    int a;
    int s;
    int k;
    int np;
    exp_q.delete();
    exp_fc = 0;
    exp_ab = 1'b0;
    exp_done = 0;
    k = 0;
    if (!(multi && st > sp)) begin
      a = int'(st);
      forever begin
        for (int r = 0; r <= int'(nl); r++) base.push_back((a << 2) | r);
        if (!multi || stp == 16'd0) break;
        s = a + int'(stp);
        if (s > int'(sp)) break;
        a = s;
      end
    end
    np = loopm ? passes + 1 : 1;
    for (int p = 0; p < np && !exp_ab; p++) begin
      exp_done++;
      foreach (base[i]) begin
        exp_q.push_back(base[i]);
        if (k < 32 && fmask[k]) begin
          if (exp_fc < 65535) exp_fc++;
          if (!ign) exp_ab = 1'b1;
        end
        k++;
        if (exp_ab) break;
      end
    end
  endtask

  task automatic wait_op_req(input string tag);
    for (int i = 0; i < 20 && !op_req; i++) @(negedge mclk);
    check(tag, 32'(op_req), 32'd1);
  endtask

  // Start a sweep, act as the op FSM with random ack latency, then compare against the model.
  task automatic run_sweep(input string tag, input logic [15:0] st, input logic [15:0] sp,
                           input logic [15:0] stp, input logic [1:0] nl, input bit multi,
                           input bit loopm, input bit ign, input logic [31:0] fmask,
                           input int passes);
    int  done_cnt = 0;
    int  acks = 0;
    int  delay = 0;
    bit  in_op = 1'b0;
    int  exp_fc;
    bit  exp_ab;
    int  exp_done;
    int  n;
    got_q.delete();
    address_start = st;
    address_stop = sp;
    address_step = stp;
    num_levels = nl;
    use_multi_addrs = multi;
    loop_mode = loopm;
    ignore_failures = ign;
    go = 1'b1;
    @(negedge mclk);
    if (!loopm) go = 1'b0;
    address_start = 16'($urandom);
    address_stop = 16'($urandom);
    address_step = 16'($urandom);
    num_levels = 2'($urandom);
    use_multi_addrs = 1'($urandom);
    loop_mode = 1'($urandom);
    ignore_failures = 1'($urandom);
    for (int cyc = 0; cyc < 5000; cyc++) begin
      op_ack = 1'b0;
      op_fail = 1'b0;
      if (!busy) break;
      if (done) done_cnt++;
      if (op_req) begin
        if (!in_op) begin
          got_q.push_back(pack_op(addr_out, rangei));
          in_op = 1'b1;
          delay = int'($urandom_range(0, 3));
          if (loopm && done_cnt >= passes) go = 1'b0;
        end else begin
          check({tag, " hold"}, 32'(pack_op(addr_out, rangei)), 32'(got_q[got_q.size()-1]));
        end
        if (delay == 0) begin
          op_ack = 1'b1;
          op_fail = (acks < 32) ? fmask[acks] : 1'b0;
          acks++;
          in_op = 1'b0;
        end else begin
          delay--;
        end
      end
      @(negedge mclk);
    end
    op_ack = 1'b0;
    op_fail = 1'b0;
    go = 1'b0;
    check({tag, " finish"}, 32'(busy), 32'd0);
    model(st, sp, stp, nl, multi, ign, loopm, fmask, passes, exp_fc, exp_ab, exp_done);
    check({tag, " op count"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s op%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    check({tag, " fail_count"}, 32'(fail_count), 32'(exp_fc));
    check({tag, " aborted"}, 32'(aborted), 32'(exp_ab));
    check({tag, " done pulses"}, 32'(done_cnt), 32'(exp_done));
    check({tag, " state"}, 32'(state), 32'd0);
    repeat (2) @(negedge mclk);
  endtask

  initial begin
    repeat (3) @(negedge mclk);
    check("reset state", 32'(state), 32'd0);
    check("reset op_req", 32'(op_req), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset aborted", 32'(aborted), 32'd0);
    check("reset fail_count", 32'(fail_count), 32'd0);
    check("reset addr_out", 32'(addr_out), 32'd0);
    check("reset rangei", 32'(rangei), 32'd0);
    rst = 1'b0;
    @(negedge mclk);

    // Exact cycle timing of a single-address, single-range op.
    address_start = 16'h0010;
    address_stop = 16'h0000;
    address_step = 16'h0001;
    num_levels = 2'd0;
    use_multi_addrs = 1'b0;
    go = 1'b1;
    @(negedge mclk);
    go = 1'b0;
    check("lat issue state", 32'(state), 32'd1);
    check("lat op_req early", 32'(op_req), 32'd0);
    check("lat busy", 32'(busy), 32'd1);
    @(negedge mclk);
    check("lat op_req", 32'(op_req), 32'd1);
    check("lat addr", 32'(addr_out), 32'h10);
    check("lat rangei", 32'(rangei), 32'd0);
    op_ack = 1'b1;
    @(negedge mclk);
    op_ack = 1'b0;
    check("lat op_req drop", 32'(op_req), 32'd0);
    check("lat done early", 32'(done), 32'd0);
    @(negedge mclk);
    check("lat done", 32'(done), 32'd1);
    @(negedge mclk);
    check("lat done pulse", 32'(done), 32'd0);
    check("lat idle", 32'(busy), 32'd0);
    check("lat fail_count", 32'(fail_count), 32'd0);

    run_sweep("single", 16'h0010, 16'h0000, 16'h0001, 2'd0, 1'b0, 1'b0, 1'b0, 32'h0, 0);
    run_sweep("sweep", 16'd2, 16'd8, 16'd3, 2'd1, 1'b1, 1'b0, 1'b0, 32'h0, 0);
    run_sweep("wrap", 16'hFFF0, 16'hFFFF, 16'h0020, 2'd2, 1'b1, 1'b0, 1'b0, 32'h0, 0);
    run_sweep("empty", 16'd9, 16'd3, 16'd1, 2'd1, 1'b1, 1'b0, 1'b0, 32'h0, 0);
    run_sweep("step0", 16'd7, 16'd20, 16'd0, 2'd3, 1'b1, 1'b0, 1'b1, 32'h9, 0);
    run_sweep("abort", 16'd2, 16'd8, 16'd3, 2'd1, 1'b1, 1'b0, 1'b0, 32'h2, 0);
    run_sweep("ignore", 16'd2, 16'd8, 16'd3, 2'd1, 1'b1, 1'b0, 1'b1, 32'h2, 0);
    run_sweep("loop", 16'd4, 16'd5, 16'd1, 2'd0, 1'b1, 1'b1, 1'b1, 32'h24, 3);

    for (int i = 0; i < 6; i++) begin
      run_sweep($sformatf("rand%0d", i), 16'($urandom_range(0, 40)), 16'($urandom_range(0, 40)),
                16'($urandom_range(0, 6)), 2'($urandom), 1'($urandom), 1'b0, 1'($urandom),
                $urandom & $urandom, 0);
    end

    // Reset in the middle of a handshake, with an ack landing in the reset cycle.
    address_start = 16'd2;
    address_stop = 16'd8;
    address_step = 16'd3;
    num_levels = 2'd1;
    use_multi_addrs = 1'b1;
    loop_mode = 1'b0;
    ignore_failures = 1'b1;
    go = 1'b1;
    @(negedge mclk);
    go = 1'b0;
    wait_op_req("rst first op");
    op_ack = 1'b1;
    op_fail = 1'b1;
    @(negedge mclk);
    op_ack = 1'b0;
    op_fail = 1'b0;
    wait_op_req("rst second op");
    check("rst pre fail_count", 32'(fail_count), 32'd1);
    rst = 1'b1;
    op_ack = 1'b1;
    op_fail = 1'b1;
    @(negedge mclk);
    rst = 1'b0;
    op_ack = 1'b0;
    op_fail = 1'b0;
    check("rst op_req", 32'(op_req), 32'd0);
    check("rst state", 32'(state), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst fail_count", 32'(fail_count), 32'd0);
    check("rst addr_out", 32'(addr_out), 32'd0);
    op_ack = 1'b1;
    op_fail = 1'b1;
    @(negedge mclk);
    op_ack = 1'b0;
    op_fail = 1'b0;
    @(negedge mclk);
    check("stray ack state", 32'(state), 32'd0);
    check("stray ack op_req", 32'(op_req), 32'd0);
    check("stray ack fail_count", 32'(fail_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
